// File: rtl/fp_addsub_pipe.sv
// Four-stage elastic floating-point adder/subtractor (unpack, align, add/normalise, round/pack).
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   ip1,
    input  logic [EXP_W+MAN_W:0]   ip2,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 4;
    localparam int SH_MAX = MAN_W + 3;
    localparam int SHW    = $clog2(SH_MAX + 1);
    localparam int LZW    = $clog2(MW + 1);
    localparam int XW     = EXP_W + LZW + 2;
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

    logic r1_valid, r2_valid, r3_valid, r4_valid;
    logic w_ld1, w_ld2, w_ld3, w_ld4;

    // Each stage loads when empty or when the stage below it loads.
    assign w_ld4     = !r4_valid || out_ready;
    assign w_ld3     = !r3_valid || w_ld4;
    assign w_ld2     = !r2_valid || w_ld3;
    assign w_ld1     = !r1_valid || w_ld2;
    assign in_ready  = w_ld1;
    assign out_valid = r4_valid;

    // ---------------- S1: unpack / classify / swap ----------------
    logic             w_a_s, w_b_s, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
    logic [EXP_W-1:0] w_a_e, w_b_e, w_l_e, w_s_e;
    logic [MAN_W-1:0] w_a_f, w_b_f;
    logic [W-2:0]     w_a_mag, w_b_mag, w_l_mag, w_s_mag;
    logic             w_l_s, w_s_s;

    assign w_a_s   = ip1[W-1];
    assign w_b_s   = ip2[W-1] ^ sub;
    assign w_a_e   = ip1[W-2:MAN_W];
    assign w_b_e   = ip2[W-2:MAN_W];
    assign w_a_f   = ip1[MAN_W-1:0];
    assign w_b_f   = ip2[MAN_W-1:0];
    assign w_a_nan = (&w_a_e) && (|w_a_f);
    assign w_b_nan = (&w_b_e) && (|w_b_f);
    assign w_a_inf = (&w_a_e) && !(|w_a_f);
    assign w_b_inf = (&w_b_e) && !(|w_b_f);
    // Denormals flush to zero magnitude so they never win the swap.
    assign w_a_mag = (w_a_e == '0) ? '0 : ip1[W-2:0];
    assign w_b_mag = (w_b_e == '0) ? '0 : ip2[W-2:0];
    assign w_swap  = w_b_mag > w_a_mag;
    assign w_l_mag = w_swap ? w_b_mag : w_a_mag;
    assign w_s_mag = w_swap ? w_a_mag : w_b_mag;
    assign w_l_s   = w_swap ? w_b_s : w_a_s;
    assign w_s_s   = w_swap ? w_a_s : w_b_s;
    assign w_l_e   = w_l_mag[W-2:MAN_W];
    assign w_s_e   = w_s_mag[W-2:MAN_W];

    logic             r1_sl, r1_eff_sub, r1_zsign, r1_nan, r1_inf;
    logic [EXP_W-1:0] r1_el, r1_d;
    logic [MAN_W:0]   r1_ml, r1_ms;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
        end else if (w_ld1) begin
            r1_valid   <= in_valid;
            r1_sl      <= w_l_s;
            r1_el      <= w_l_e;
            r1_ml      <= {|w_l_e, w_l_mag[MAN_W-1:0]};
            r1_ms      <= {|w_s_e, w_s_mag[MAN_W-1:0]};
            r1_d       <= w_l_e - w_s_e;
            r1_eff_sub <= w_l_s ^ w_s_s;
            r1_zsign   <= w_l_s & w_s_s;
            r1_nan     <= w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s ^ w_b_s));
            r1_inf     <= w_a_inf || w_b_inf;
        end
    end

    // ---------------- S2: align smaller operand ----------------
    logic [SHW-1:0] w_sh;
    logic [MW-1:0]  w_ext_s, w_shifted, w_mask, w_aligned;
    logic           w_sticky;

    always_comb begin
        w_sh = SHW'(SH_MAX);
        if (int'(r1_d) <= SH_MAX) w_sh = SHW'(r1_d);
    end

    assign w_ext_s   = {r1_ms, 3'b000};
    assign w_shifted = w_ext_s >> w_sh;
    assign w_mask    = ~({MW{1'b1}} << w_sh);
    assign w_sticky  = |(w_ext_s & w_mask);
    assign w_aligned = {w_shifted[MW-1:1], w_shifted[0] | w_sticky};

    logic             r2_sl, r2_eff_sub, r2_zsign, r2_nan, r2_inf;
    logic [EXP_W-1:0] r2_el;
    logic [MW-1:0]    r2_big, r2_small;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
        end else if (w_ld2) begin
            r2_valid   <= r1_valid;
            r2_sl      <= r1_sl;
            r2_el      <= r1_el;
            r2_big     <= {r1_ml, 3'b000};
            r2_small   <= w_aligned;
            r2_eff_sub <= r1_eff_sub;
            r2_zsign   <= r1_zsign;
            r2_nan     <= r1_nan;
            r2_inf     <= r1_inf;
        end
    end

    // ---------------- S3: add / normalise ----------------
    function automatic logic [LZW-1:0] f_lzc(input logic [MW-1:0] v);
        f_lzc = '0;
        for (int i = 0; i < MW; i++)
            if (v[i]) f_lzc = LZW'(MW - 1 - i);
    endfunction

    logic [MW:0]           w_sum;
    logic [LZW-1:0]        w_lzc;
    logic [MW-1:0]         w_norm;
    logic signed [XW-1:0]  w_el_x, w_exp3;
    logic                  w_zero3;

    assign w_sum   = r2_eff_sub ? ({1'b0, r2_big} - {1'b0, r2_small})
                                : ({1'b0, r2_big} + {1'b0, r2_small});
    assign w_lzc   = f_lzc(w_sum[MW-1:0]);
    assign w_el_x  = XW'(r2_el);
    assign w_zero3 = (w_sum == '0);

    always_comb begin
        w_norm = w_sum[MW-1:0] << w_lzc;
        w_exp3 = w_el_x - XW'(w_lzc);
        if (w_sum[MW]) begin
            w_norm = {w_sum[MW:2], w_sum[1] | w_sum[0]};
            w_exp3 = w_el_x + XW'(1);
        end
    end

    logic                 r3_sign, r3_nan, r3_inf, r3_zero;
    logic signed [XW-1:0] r3_exp;
    logic [MW-1:0]        r3_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_valid <= 1'b0;
        end else if (w_ld3) begin
            r3_valid <= r2_valid;
            r3_sign  <= w_zero3 ? r2_zsign : r2_sl;
            r3_exp   <= w_exp3;
            r3_m     <= w_norm;
            r3_nan   <= r2_nan;
            r3_inf   <= r2_inf;
            r3_zero  <= w_zero3;
        end
    end

    // ---------------- S4: round / pack ----------------
    logic                 w_inc;
    logic [MAN_W+1:0]     w_rnd;
    logic signed [XW-1:0] w_exp4;
    logic [MAN_W-1:0]     w_frac4;
    logic [W-1:0]         w_res;
    logic [3:0]           w_flg;

`ifdef FPADD_RNE_EN
    assign w_inc = r3_m[2] & (r3_m[1] | r3_m[0] | r3_m[3]);
`else
    logic w_unused_grs;
    assign w_inc        = 1'b0;
    assign w_unused_grs = ^r3_m[2:0];
`endif

    assign w_rnd = {1'b0, r3_m[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};

    always_comb begin
        w_exp4  = r3_exp;
        w_frac4 = w_rnd[MAN_W-1:0];
        if (w_rnd[MAN_W+1]) begin
            w_exp4  = r3_exp + XW'(1);
            w_frac4 = w_rnd[MAN_W:1];
        end
        w_res = {r3_sign, w_exp4[EXP_W-1:0], w_frac4};
        w_flg = 4'b0000;
        if (r3_nan) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flg = 4'b1000;
        end else if (r3_inf) begin
            w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r3_zero) begin
            w_res = {r3_sign, {(W-1){1'b0}}};
            w_flg = 4'b0001;
        end else if (w_exp4 >= EMAX_X) begin
            w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0100;
        end else if (w_exp4[XW-1] || (w_exp4 == '0)) begin
            w_res = {r3_sign, {(W-1){1'b0}}};
            w_flg = 4'b0011;
        end
    end

    logic [W-1:0] r_result;
    logic [3:0]   r_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r4_valid <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_ld4) begin
            r4_valid <= r3_valid;
            if (r3_valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, backpressure and mid-flight reset.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] ip1, ip2, result;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ip1(ip1), .ip2(ip2), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

`ifdef FPADD_RNE_EN
    localparam logic [31:0] R8  = 32'h3F800002;
    localparam logic [31:0] R19 = 32'h3F800001;
`else
    localparam logic [31:0] R8  = 32'h3F800001;
    localparam logic [31:0] R19 = 32'h3F800000;
`endif

    localparam int NV = 20;
    logic [31:0] va [NV] = '{32'h3FC00000, 32'h40600000, 32'h40350000, 32'h40400000, 32'h7F7FFFFF,
                             32'h7F800000, 32'h007FFFFF, 32'h00800001, 32'h3F800001, 32'h7F800000,
                             32'hFF800000, 32'h7F800001, 32'h80000000, 32'h3F800000, 32'h80000000,
                             32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb [NV] = '{32'h40400000, 32'h40B00000, 32'h402C0000, 32'hC0400000, 32'h7F7FFFFF,
                             32'hFF800000, 32'h007FFFFF, 32'h00800000, 32'h33800000, 32'h3F800000,
                             32'hFF800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h00000000,
                             32'h7F800000, 32'hBF000000, 32'h3F800000, 32'h33800000, 32'h33C00000};
    logic        vs [NV] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] vr [NV] = '{32'h40900000, 32'h41100000, 32'h3E100000, 32'h00000000, 32'h7F800000,
                             32'h7FC00000, 32'h00000000, 32'h00000000, R8,           32'h7F800000,
                             32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h80000000,
                             32'h7FC00000, 32'h3F000000, 32'hBF800000, 32'h3F800000, R19};
    logic [3:0]  vf [NV] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h8, 4'h1, 4'h3, 4'h0, 4'h0,
                             4'h0, 4'h8, 4'h1, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          issue_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_acc = 0, n_out = 0;
    bit          prev_stall = 0;
    logic [35:0] prev_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (!rst && prev_stall && out_valid)
            check("hold_stable", {result, flags}, prev_out);
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h flags %b, expected no output", result, flags);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("flags", flags, e.flg);
                if (e.lat_chk) check("latency", cyc - e.issue_cyc, 4);
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_out   = {result, flags};
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int idx, input bit lat);
        int   waited = 0;
        exp_t e;
        in_valid = 1'b1;
        ip1 = va[idx];
        ip2 = vb[idx];
        sub = vs[idx];
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: vector %0d, in_ready got 0, expected 1", idx);
        end else begin
            e.res = vr[idx];
            e.flg = vf[idx];
            e.issue_cyc = cyc;
            e.lat_chk = lat;
            sb_q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        int base_acc, base_out;
        rst = 1'b1; in_valid = 1'b0; ip1 = '0; ip2 = '0; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors, back-to-back, no backpressure.
        for (int i = 0; i < NV; i++) send(i, 1'b1);
        in_valid = 1'b0;
        drain("drain_directed");

        // Backpressure: 8 ops against a stalled consumer.
        @(posedge clk); #1;
        out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (12) @(negedge clk);
                check("accepts_while_stalled", n_acc - base_acc, 4);
                check("in_ready_while_stalled", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("outputs_after_release", n_out - base_out, 8);

        // Reset with three operations in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(i, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        base_out = n_out;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("out_valid_after_reset", out_valid, 0);
        repeat (10) @(negedge clk);
        check("no_output_after_reset", n_out - base_out, 0);

        // Recovery after reset.
        @(posedge clk); #1;
        send(1, 1'b1);
        in_valid = 1'b0;
        drain("drain_recovery");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the single-precision combinational-result FPU adder.
- Generic exponent/mantissa widths, per-operation add/sub select.
- valid/ready elastic pipeline with backpressure.
- Exception flags.
- Sits between operand-issue logic and the result writeback/consumer.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa (fraction) width (>=3); word width W = 1+EXP_W+MAN_W (derived localparam, 32 at defaults)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
ip1  in  W  operand A (sign|exp|frac)
ip2  in  W  operand B
sub  in  1  0: A+B, 1: A-B (B sign inverted at stage 1)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  packed result
flags  out  4  {nan, ovf, unf, zero}, aligned with result

Behaviour:
- Reset: on a clk edge with rst=1, all stage valid bits clear. out_valid=0, result=0, flags=0. in_ready=1 the cycle after reset. Reset mid-operation discards all in-flight operations, with no partial output.
- Handshake: transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Each stage register loads when it is empty or its downstream stage loads (bubble-collapsing).
  - in_ready = !s1_valid | s1_advances.
  - result and flags hold stable while out_valid&!out_ready.
- Latency: exactly 4 cycles from accept to out_valid with no stall. Throughput is 1 op/cycle.
- Stages:
  - S1 unpack/compare: classify zero/denormal/inf/NaN; apply sub; swap so |A|>=|B|; exponent difference d.
  - S2 align: shift smaller significand right by min(d, MAN_W+3), collecting guard, round and sticky bits (sticky = OR of shifted-out bits).
  - S3 add/normalise: add or subtract according to effective sign; leading-zero count; left/right normalise; exponent adjust.
  - S4 round/pack: round, renormalise on mantissa carry-out, pack, set flags.
- Arithmetic rules:
  - Inputs with exp=0 are flushed to signed zero (no denormal support).
  - Exact cancellation gives +0, except (-0)+(-0) = -0.
  - Result exponent >= 2^EXP_W-1 after rounding gives signed infinity and ovf=1.
  - Result exponent <=0 gives signed zero and unf=1.
  - zero=1 whenever the packed result is ±0, including the unf case.
- Specials:
  - Any NaN input, or inf-inf with effective subtraction, gives canonical quiet NaN: sign 0, exp all-ones, frac MSB 1, rest 0; nan=1.
  - inf op finite gives that inf, with no flags.
  - inf+inf with same effective sign gives inf.
- Simultaneous accept and emit in one cycle with a full pipeline: no bubble, no loss, no duplication.

Optional Feature:
FPADD_RNE_EN
- Defined: round-to-nearest-even using guard/round/sticky. Ties round to the even fraction LSB.
- Undefined: truncation (round toward zero). G/R/S are ignored for rounding, and overflow saturates only on true exponent overflow.
- Flags and latency are identical in both builds.

Test Plan:
- Defaults, sub=0, ip1=0x3FC00000 (1.5), ip2=0x40400000 (3.0) -> result 0x40900000 (4.5) exactly 4 cycles later, flags=0. Also 0x40600000+0x40B00000 -> 0x41100000 (9.0).
- sub=1, ip1=0x40350000 (2.828125), ip2=0x402C0000 -> 0x3E100000 (0.140625). Also sub=0, 0x40400000+0xC0400000 -> 0x00000000, zero=1.
- 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, ovf=1. 0x7F800000+0xFF800000 -> 0x7FC00000, nan=1.
- 0x007FFFFF+0x007FFFFF (denormals) -> 0x00000000, zero=1. 0x00800001-0x00800000 (sub=1) -> 0x00000000, unf=1, zero=1.
- 0x3F800001+0x33800000 -> with FPADD_RNE_EN 0x3F800002; without it 0x3F800001.
- Backpressure and reset:
  - Stream 8 back-to-back ops with out_ready=0: in_ready drops after 4 accepts.
  - Release out_ready: all 8 results appear in order, with none lost or duplicated.
  - Assert rst with 3 ops in flight: out_valid=0 next cycle and none of those 3 results are ever emitted.
